prog_loader: RTL and testbench

Byte-stream program loader sitting directly upstream of the CPU fetch path. It receives a framed byte stream, assembles 14-bit instruction words, and writes them into the write port of the dual-port program RAM whose read port is addressed by the fetch stage's MAR. It holds the CPU in reset (`cpu_rst`) until a complete, verified image is in memory, then releases it so execution starts from address 0.

---
 rtl/prog_loader_pkg.sv | 30 +++
 rtl/prog_loader.sv | 181 ++++++++++++++++++
 tb/tb_prog_loader.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared definitions for the byte-stream program loader.
//   - default geometry of the program memory (address width, word width, depth)
//   - loader FSM state encoding
//   - small helper classifying the states in which bytes are accepted
package prog_loader_pkg;

  localparam int DEF_ADDR_W = 11;
  localparam int DEF_DATA_W = 14;
  localparam int DEF_DEPTH  = 2048;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_W_HI   = 3'd3,
    S_W_LO   = 3'd4,
    S_CHK    = 3'd5,
    S_DONE   = 3'd6,
    S_ERR    = 3'd7
  } state_t;

  // True in the states that consume frame bytes (LEN_HI..CHK).
  function automatic logic is_loading(input state_t s);
    case (s)
      S_LEN_HI, S_LEN_LO, S_W_HI, S_W_LO, S_CHK: return 1'b1;
      default:                                   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/prog_loader.sv
// prog_loader: receives a framed byte stream, assembles 14-bit instruction
// words, writes them to the program RAM write port and holds the CPU in reset
// until a complete, verified image is loaded.
//
// Frame: LEN_HI LEN_LO {W_HI W_LO} x N [CHK]
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   start             begin a load (honoured in IDLE, DONE, ERR only)
//   byte_valid/data   byte source; byte_ready says a byte is taken this edge
//   mem_we/addr/wdata registered one-cycle write to the program RAM
//   cpu_rst           1 everywhere except DONE
//   busy/done/err     load status levels
//
// Build option: PROG_LOADER_CHECKSUM_EN -- when defined a trailing CHK byte
// is expected and the 8-bit sum of every frame byte must be 0x00; when
// undefined the FSM goes straight to DONE after the last word.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  state_t            state;
  state_t            state_nxt;
  logic [7:0]        len_hi;
  logic [15:0]       len;
  logic [15:0]       word_cnt;
  logic [5:0]        word_hi;
  logic [ADDR_W-1:0] wr_addr;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]        sum;
`endif

  logic        xfer;
  logic        restart;
  logic [15:0] len_in;

  assign xfer    = byte_valid && byte_ready;
  assign restart = start && !is_loading(state);
  assign len_in  = {len_hi, byte_data};

  // Next-state decode; every output below is registered from state_nxt so
  // the flags change on the same edge as the state.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) state_nxt = S_LEN_HI;
        else       state_nxt = state;
      end
      S_LEN_HI: begin
        if (xfer) state_nxt = S_LEN_LO;
        else      state_nxt = state;
      end
      S_LEN_LO: begin
        if (xfer) begin
          if (len_in == 16'd0 || {1'b0, len_in} > DEPTH_L) state_nxt = S_ERR;
          else                                              state_nxt = S_W_HI;
        end else begin
          state_nxt = state;
        end
      end
      S_W_HI: begin
        // Bits 7:6 of the high byte are reserved and must be zero.
        if (xfer) begin
          if (byte_data[7:6] != 2'b00) state_nxt = S_ERR;
          else                         state_nxt = S_W_LO;
        end else begin
          state_nxt = state;
        end
      end
      S_W_LO: begin
        if (xfer) begin
          if (word_cnt + 16'd1 == len) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            state_nxt = S_CHK;
`else
            state_nxt = S_DONE;
`endif
          end else begin
            state_nxt = S_W_HI;
          end
        end else begin
          state_nxt = state;
        end
      end
      S_CHK: begin
`ifdef PROG_LOADER_CHECKSUM_EN
        // Running sum already covers LEN_HI..last W_LO; add CHK itself.
        if (xfer) begin
          if (sum + byte_data == 8'h00) state_nxt = S_DONE;
          else                          state_nxt = S_ERR;
        end else begin
          state_nxt = state;
        end
`else
        state_nxt = S_ERR;
`endif
      end
      default: state_nxt = S_ERR;
    endcase
  end

  // State, registered status outputs, frame datapath and RAM write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      byte_ready <= 1'b0;
      busy       <= 1'b0;
      cpu_rst    <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      len_hi     <= 8'd0;
      len        <= 16'd0;
      word_cnt   <= 16'd0;
      word_hi    <= 6'd0;
      wr_addr    <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum        <= 8'd0;
`endif
    end else begin
      state      <= state_nxt;
      byte_ready <= is_loading(state_nxt);
      busy       <= is_loading(state_nxt);
      cpu_rst    <= (state_nxt != S_DONE);
      done       <= (state_nxt == S_DONE);
      err        <= (state_nxt == S_ERR);
      mem_we     <= 1'b0;

      if (restart) begin
        wr_addr  <= '0;
        word_cnt <= 16'd0;
`ifdef PROG_LOADER_CHECKSUM_EN
        sum      <= 8'd0;
`endif
      end else if (xfer) begin
`ifdef PROG_LOADER_CHECKSUM_EN
        sum <= sum + byte_data;
`endif
        case (state)
          S_LEN_HI: len_hi  <= byte_data;
          S_LEN_LO: len     <= len_in;
          S_W_HI:   word_hi <= byte_data[5:0];
          S_W_LO: begin
            mem_we    <= 1'b1;
            mem_addr  <= wr_addr;
            mem_wdata <= DATA_W'({word_hi, byte_data});
            wr_addr   <= wr_addr + 1'b1;
            word_cnt  <= word_cnt + 16'd1;
          end
          default: ;
        endcase
      end else begin
        mem_we <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized self-checking bench for prog_loader. A frame
// interpreter computes the expected writes, the number of bytes the loader
// should take and the final outcome; a monitor records every RAM write.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_we;
  logic [10:0] mem_addr;
  logic [13:0] mem_wdata;
  logic        cpu_rst;
  logic        busy;
  logic        done;
  logic        err;

  prog_loader dut (
    .clk(clk), .rst(rst), .start(start),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_rst(cpu_rst), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]  frame[$];
  logic [13:0] exp_w[$];
  bit          exp_ok;
  int          exp_used;
  logic [10:0] got_a[$];
  logic [13:0] got_d[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Write monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      got_a.push_back(mem_addr);
      got_d.push_back(mem_wdata);
    end
  end

  // Frame interpreter: walks the byte list by the frame rules.
  task automatic model();
    int n;
    logic [7:0] s;
    exp_w.delete();
    exp_ok = 1'b0;
    n = {frame[0], frame[1]};
    exp_used = 2;
    if (n == 0 || n > 2048) return;
    for (int i = 0; i < n; i++) begin
      exp_used++;
      if (frame[2+2*i] >= 8'h40) return;
      exp_used++;
      exp_w.push_back({frame[2+2*i][5:0], frame[3+2*i]});
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    s = 8'h00;
    for (int i = 0; i <= exp_used; i++) s = s + frame[i];
    exp_used++;
    exp_ok = (s == 8'h00);
`else
    s = 8'h00;
    exp_ok = 1'b1;
`endif
  endtask

  // Builds a frame with n words; word index bad gets a reserved bit set.
  task automatic build(input int n, input int bad, input bit corrupt);
    logic [7:0] s;
    logic [7:0] b;
    int nw;
    frame.delete();
    frame.push_back(8'(n >> 8));
    frame.push_back(8'(n));
    nw = (n > 2048) ? 1 : n;
    for (int i = 0; i < nw; i++) begin
      b = 8'($urandom_range(0, 63));
      if (i == bad) b = b | (($urandom_range(0, 1) == 0) ? 8'h40 : 8'h80);
      frame.push_back(b);
      frame.push_back(8'($urandom_range(0, 255)));
    end
    s = 8'h00;
    foreach (frame[i]) s = s + frame[i];
    frame.push_back(8'h00 - s + (corrupt ? 8'h01 : 8'h00));
  endtask

  task automatic pulse_start();
    byte_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stalls);
    int t;
    if (stalls) begin
      byte_valid = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    byte_valid = 1'b1;
    byte_data  = b;
    t = 0;
    while (byte_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("ready_timeout", 32'd0, 32'd1);
    else @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic run_frame(input string tag, input bit stalls, input bit mid_start);
    model();
    got_a.delete();
    got_d.delete();
    pulse_start();
    check({tag, "_busy0"}, {31'd0, busy}, 32'd1);
    check({tag, "_rdy0"}, {31'd0, byte_ready}, 32'd1);
    check({tag, "_cpurst0"}, {31'd0, cpu_rst}, 32'd1);
    check({tag, "_done0"}, {31'd0, done}, 32'd0);
    for (int i = 0; i < exp_used; i++) begin
      if (mid_start && i == 3) pulse_start();
      send_byte(frame[i], stalls);
    end
    check({tag, "_done"}, {31'd0, done}, {31'd0, exp_ok});
    check({tag, "_err"}, {31'd0, err}, {31'd0, !exp_ok});
    check({tag, "_cpurst"}, {31'd0, cpu_rst}, {31'd0, !exp_ok});
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_rdy"}, {31'd0, byte_ready}, 32'd0);
    @(negedge clk);
    check({tag, "_nwr"}, got_a.size(), exp_w.size());
    if (got_a.size() == exp_w.size()) begin
      foreach (exp_w[i]) begin
        check({tag, "_addr"}, {21'd0, got_a[i]}, i);
        check({tag, "_data"}, {18'd0, got_d[i]}, {18'd0, exp_w[i]});
      end
    end
  endtask

  task automatic set_frame_a();
    frame = '{8'h00, 8'h02, 8'h30, 8'h05, 8'h3E, 8'h03, 8'h88};
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rdy"}, {31'd0, byte_ready}, 32'd0);
    check({tag, "_we"}, {31'd0, mem_we}, 32'd0);
    check({tag, "_addr"}, {21'd0, mem_addr}, 32'd0);
    check({tag, "_wdata"}, {18'd0, mem_wdata}, 32'd0);
    check({tag, "_cpurst"}, {31'd0, cpu_rst}, 32'd1);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_err"}, {31'd0, err}, 32'd0);
  endtask

  initial begin
    int n;
    int bad;
    rst = 1'b1;
    start = 1'b0;
    byte_valid = 1'b0;
    byte_data = 8'h00;
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_rdy", {31'd0, byte_ready}, 32'd0);

    // Reference frame, then the same frame with start pulsed mid-load.
    set_frame_a();
    run_frame("frameA", 1'b0, 1'b0);
    set_frame_a();
    run_frame("frameA_midstart", 1'b0, 1'b1);

    // Second load from DONE: reserved bit set in W_HI.
    frame = '{8'h00, 8'h01, 8'hC0, 8'hFF, 8'h40};
    run_frame("reload_bad", 1'b0, 1'b0);

    // Bad checksum (only meaningful with the checksum option).
    frame = '{8'h00, 8'h02, 8'h30, 8'h05, 8'h3E, 8'h03, 8'h89};
    run_frame("badchk", 1'b0, 1'b0);

    // Length errors and reserved bit.
    frame = '{8'h00, 8'h00, 8'h30, 8'h05};
    run_frame("len0", 1'b0, 1'b0);
    frame = '{8'h08, 8'h01, 8'h30, 8'h05};
    run_frame("len2049", 1'b0, 1'b0);
    frame = '{8'h00, 8'h01, 8'h70, 8'h05, 8'h8A};
    run_frame("whi70", 1'b0, 1'b0);

    // Maximum length image, addresses 0..2047.
    build(2048, -1, 1'b0);
    run_frame("full", 1'b0, 1'b0);

    // Randomized frames with random stalls.
    for (int k = 0; k < 25; k++) begin
      n = $urandom_range(1, 6);
      if ($urandom_range(0, 9) == 0) n = 2049 + $urandom_range(0, 100);
      bad = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 5) : -1;
      build(n, bad, $urandom_range(0, 4) == 0);
      run_frame("rand", 1'b1, 1'b0);
    end

    // Reset after the first word of a load.
    set_frame_a();
    got_a.delete();
    got_d.delete();
    pulse_start();
    for (int i = 0; i < 4; i++) send_byte(frame[i], 1'b0);
    @(negedge clk);
    check("midrst_firstwr", got_a.size(), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_idle_rdy", {31'd0, byte_ready}, 32'd0);
    set_frame_a();
    run_frame("after_rst", 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
